// File: rtl/merge_arb.sv
// merge_arb: N-master to 1-slave merge for the native valid/ready bus.
//
// Purpose:
//   Picks one requesting master (fixed priority or round-robin), forwards its
//   request to the slave and routes the slave response back to it only. Once a
//   request is forwarded without an immediate ready, the grant is locked until
//   the slave completes it. An optional watchdog force-completes a stalled
//   transaction with rdata=0.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   m_req   in   N_MASTERS x {valid, addr, wdata, wstrb}
//   m_resp  out  N_MASTERS x {rdata, ready}
//   s_req   out  request to slave {valid, addr, wdata, wstrb}
//   s_resp  in   slave response {rdata, ready}
//   grant   out  one-hot granted master
//   timeout out  one-cycle pulse on watchdog expiry
module merge_arb #(
    parameter int N_MASTERS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RR_EN     = 1,
    parameter int TIMEOUT   = 0,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          timeout
);

    localparam int IDX_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    // Set for the single cycle after a multi-cycle completion, during which
    // no arbitration takes place.
    logic                 gap_q, gap_d;

    logic [N_MASTERS-1:0] valid_s;
    logic [IDX_W-1:0]     win_s;
    logic                 win_vld_s;
    logic                 ready_s;
    logic [REQ_W-1:0]     s_req_s;
    logic [N_MASTERS*RESP_W-1:0] m_resp_s;
    logic [N_MASTERS-1:0] grant_s;
    logic                 timeout_s;

    // Index of the master after i, wrapping at N_MASTERS.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        int n;
        n = int'(i) + 1;
        if (n >= N_MASTERS) begin
            n = 0;
        end else begin
            n = n;
        end
        return IDX_W'(n);
    endfunction

    assign ready_s = s_resp[0];

    // Extract the valid bit (MSB) of every master request slice.
    always_comb begin
        valid_s = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            valid_s[IDX_W'(k)] = m_req[k*REQ_W + REQ_W - 1];
        end
    end

    // Arbitration over valid bits: round-robin from rr_ptr, or highest index.
    always_comb begin
        int idx;
        idx       = 0;
        win_s     = '0;
        win_vld_s = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (RR_EN != 0) begin
                idx = (int'(rr_ptr_q) + i) % N_MASTERS;
                if (!win_vld_s && valid_s[IDX_W'(idx)]) begin
                    win_s     = IDX_W'(idx);
                    win_vld_s = 1'b1;
                end else begin
                    win_vld_s = win_vld_s;
                end
            end else begin
                if (valid_s[IDX_W'(i)]) begin
                    win_s     = IDX_W'(i);
                    win_vld_s = 1'b1;
                end else begin
                    win_vld_s = win_vld_s;
                end
            end
        end
    end

    // Next-state logic and routing of request/response for the current owner.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        wd_cnt_d  = wd_cnt_q;
        gap_d     = 1'b0;
        s_req_s   = '0;
        m_resp_s  = '0;
        grant_s   = '0;
        timeout_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld_s && !gap_q) begin
                    s_req_s = m_req[int'(win_s)*REQ_W +: REQ_W];
                    grant_s[win_s] = 1'b1;
                    m_resp_s[int'(win_s)*RESP_W +: RESP_W] = s_resp;
                    if (ready_s) begin
                        rr_ptr_d = next_idx(win_s);
                    end else begin
                        state_d  = BUSY;
                        gnt_d    = win_s;
                        wd_cnt_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                s_req_s = m_req[int'(gnt_q)*REQ_W +: REQ_W];
                grant_s[gnt_q] = 1'b1;
                m_resp_s[int'(gnt_q)*RESP_W +: RESP_W] = s_resp;
                if (ready_s) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(gnt_q);
                    gap_d    = 1'b1;
                end else if ((TIMEOUT > 0) && (wd_cnt_q == WD_W'(WD_LAST))) begin
                    // Watchdog expiry: complete towards the master, retract valid.
                    m_resp_s[int'(gnt_q)*RESP_W +: RESP_W] = {{DATA_W{1'b0}}, 1'b1};
                    s_req_s[REQ_W-1] = 1'b0;
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                    rr_ptr_d  = next_idx(gnt_q);
                    gap_d     = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced to zero while reset is asserted.
    always_comb begin
        if (rst) begin
            s_req   = '0;
            m_resp  = '0;
            grant   = '0;
            timeout = 1'b0;
        end else begin
            s_req   = s_req_s;
            m_resp  = m_resp_s;
            grant   = grant_s;
            timeout = timeout_s;
        end
    end

    // State, lock, round-robin pointer and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            wd_cnt_q <= wd_cnt_d;
            gap_q    <= gap_d;
        end
    end

endmodule

// File: tb/tb_merge_arb.sv
// Testbench for merge_arb: three instances (RR N=4 with watchdog, fixed
// priority N=4, single master) driven by directed per-scenario tasks.
module tb_merge_arb;

    localparam int RQ = 69;
    localparam int RS = 33;

    logic clk;
    logic rst;

    logic [4*RQ-1:0] a_mreq;
    logic [4*RS-1:0] a_mresp;
    logic [RQ-1:0]   a_sreq;
    logic [RS-1:0]   a_sresp;
    logic [3:0]      a_grant;
    logic            a_to;

    logic [4*RQ-1:0] b_mreq;
    logic [4*RS-1:0] b_mresp;
    logic [RQ-1:0]   b_sreq;
    logic [RS-1:0]   b_sresp;
    logic [3:0]      b_grant;
    logic            b_to;

    logic [RQ-1:0]   c_mreq;
    logic [RS-1:0]   c_mresp;
    logic [RQ-1:0]   c_sreq;
    logic [RS-1:0]   c_sresp;
    logic [0:0]      c_grant;
    logic            c_to;

    int checks = 0;
    int errors = 0;

    merge_arb #(.N_MASTERS(4), .DATA_W(32), .ADDR_W(32), .RR_EN(1), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst), .m_req(a_mreq), .m_resp(a_mresp), .s_req(a_sreq),
        .s_resp(a_sresp), .grant(a_grant), .timeout(a_to));

    merge_arb #(.N_MASTERS(4), .DATA_W(32), .ADDR_W(32), .RR_EN(0), .TIMEOUT(0)) u_b (
        .clk(clk), .rst(rst), .m_req(b_mreq), .m_resp(b_mresp), .s_req(b_sreq),
        .s_resp(b_sresp), .grant(b_grant), .timeout(b_to));

    merge_arb #(.N_MASTERS(1), .DATA_W(32), .ADDR_W(32), .RR_EN(1), .TIMEOUT(0)) u_c (
        .clk(clk), .rst(rst), .m_req(c_mreq), .m_resp(c_mresp), .s_req(c_sreq),
        .s_resp(c_sresp), .grant(c_grant), .timeout(c_to));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h10;
    endfunction

    function automatic logic [31:0] data_of(input int k);
        return 32'hD000_0000 + 32'(k);
    endfunction

    function automatic logic [RQ-1:0] mk(input logic v, input int k);
        return {v, addr_of(k), data_of(k), 4'hF};
    endfunction

    function automatic logic [4*RQ-1:0] reqs(input logic [3:0] mask);
        logic [4*RQ-1:0] r;
        for (int k = 0; k < 4; k++) r[k*RQ +: RQ] = mk(mask[k], k);
        return r;
    endfunction

    // Advance to the next falling edge, drive instance A, settle.
    task automatic a_cycle(input logic [3:0] mask, input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        a_mreq  = reqs(mask);
        a_sresp = {rd, rdy};
        #1;
    endtask

    task automatic test_reset;
        logic [4*RS-1:0] z;
        z = '0;
        a_mreq = reqs(4'b0011); a_sresp = {32'h1234_5678, 1'b1};
        b_mreq = reqs(4'b1111); b_sresp = {32'h1234_5678, 1'b1};
        c_mreq = mk(1'b1, 0);   c_sresp = {32'h1234_5678, 1'b1};
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_sreq !== '0) begin errors++; $display("FAIL rst_a_sreq got %h exp 0", a_sreq); end
        checks++; if (a_mresp !== z) begin errors++; $display("FAIL rst_a_mresp got %h exp 0", a_mresp); end
        checks++; if (a_grant !== 4'b0000 || a_to !== 1'b0) begin errors++; $display("FAIL rst_a_grant got %b/%b exp 0000/0", a_grant, a_to); end
        checks++; if (b_grant !== 4'b0000 || b_sreq !== '0) begin errors++; $display("FAIL rst_b got grant %b exp 0000", b_grant); end
        checks++; if (c_grant !== 1'b0 || c_mresp !== '0) begin errors++; $display("FAIL rst_c got grant %b resp %h exp 0", c_grant, c_mresp); end
        @(negedge clk);
        rst = 1'b0;
        a_mreq = '0; a_sresp = '0;
        b_mreq = '0; b_sresp = '0;
        c_mreq = '0; c_sresp = '0;
    endtask

    task automatic test_rr_zero_wait;
        logic [3:0]      exp_g [4];
        logic [4*RS-1:0] exp_r;
        int w;
        exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010; exp_g[3] = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            a_cycle(4'b1010, 1'b1, 32'hCAFE_0000 + 32'(c));
            w = (exp_g[c] == 4'b0010) ? 1 : 3;
            exp_r = '0;
            exp_r[w*RS +: RS] = {32'hCAFE_0000 + 32'(c), 1'b1};
            checks++; if (a_grant !== exp_g[c]) begin errors++; $display("FAIL rr_grant c%0d got %b exp %b", c, a_grant, exp_g[c]); end
            checks++; if (a_sreq[67:36] !== addr_of(w)) begin errors++; $display("FAIL rr_addr c%0d got %h exp %h", c, a_sreq[67:36], addr_of(w)); end
            checks++; if (a_mresp !== exp_r) begin errors++; $display("FAIL rr_resp c%0d got %h exp %h", c, a_mresp, exp_r); end
        end
    endtask

    task automatic test_lock;
        logic [4*RS-1:0] exp_r;
        a_cycle(4'b0001, 1'b0, 32'h0);
        checks++; if (a_grant !== 4'b0001) begin errors++; $display("FAIL lock_c0 got %b exp 0001", a_grant); end
        for (int c = 1; c < 3; c++) begin
            a_cycle(4'b0101, 1'b0, 32'h0);
            checks++; if (a_grant !== 4'b0001 || a_mresp !== '0) begin errors++; $display("FAIL lock_c%0d got %b resp %h exp 0001 resp 0", c, a_grant, a_mresp); end
        end
        a_cycle(4'b0101, 1'b1, 32'hDEAD_BEEF);
        exp_r = '0; exp_r[0 +: RS] = {32'hDEAD_BEEF, 1'b1};
        checks++; if (a_grant !== 4'b0001) begin errors++; $display("FAIL lock_c3 got %b exp 0001", a_grant); end
        checks++; if (a_mresp !== exp_r) begin errors++; $display("FAIL lock_resp got %h exp %h", a_mresp, exp_r); end
        a_cycle(4'b0100, 1'b0, 32'h0);
        checks++; if (a_grant !== 4'b0000 || a_sreq !== '0) begin errors++; $display("FAIL lock_idle got %b exp 0000", a_grant); end
        a_cycle(4'b0100, 1'b1, 32'h0);
        checks++; if (a_grant !== 4'b0100) begin errors++; $display("FAIL lock_c5 got %b exp 0100", a_grant); end
    endtask

    task automatic test_watchdog;
        logic [4*RS-1:0] exp_r;
        int pulses;
        pulses = 0;
        a_cycle(4'b0010, 1'b0, 32'h1234_5678);
        pulses += int'(a_to);
        checks++; if (a_grant !== 4'b0010) begin errors++; $display("FAIL wd_c0 got %b exp 0010", a_grant); end
        for (int c = 1; c <= 7; c++) begin
            a_cycle(4'b1010, 1'b0, 32'h1234_5678);
            pulses += int'(a_to);
            checks++; if (a_to !== 1'b0 || a_grant !== 4'b0010 || a_sreq[68] !== 1'b1) begin errors++; $display("FAIL wd_busy c%0d got to %b grant %b v %b exp 0 0010 1", c, a_to, a_grant, a_sreq[68]); end
        end
        a_cycle(4'b1010, 1'b0, 32'h1234_5678);
        pulses += int'(a_to);
        exp_r = '0; exp_r[1*RS +: RS] = {32'h0, 1'b1};
        checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL wd_pulse got %b exp 1", a_to); end
        checks++; if (a_mresp !== exp_r) begin errors++; $display("FAIL wd_resp got %h exp %h", a_mresp, exp_r); end
        checks++; if (a_sreq[68] !== 1'b0) begin errors++; $display("FAIL wd_valid got %b exp 0", a_sreq[68]); end
        a_cycle(4'b1000, 1'b1, 32'h0000_0BAD);
        pulses += int'(a_to);
        checks++; if (a_grant !== 4'b0000 || a_mresp !== '0) begin errors++; $display("FAIL wd_late got %b resp %h exp 0000 resp 0", a_grant, a_mresp); end
        a_cycle(4'b1000, 1'b1, 32'h0000_0BAD);
        pulses += int'(a_to);
        exp_r = '0; exp_r[3*RS +: RS] = {32'h0000_0BAD, 1'b1};
        checks++; if (a_grant !== 4'b1000 || a_mresp !== exp_r) begin errors++; $display("FAIL wd_next got %b resp %h exp 1000 resp %h", a_grant, a_mresp, exp_r); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wd_count got %0d exp 1", pulses); end
    endtask

    task automatic test_fixed_prio;
        logic [4*RS-1:0] exp_r;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            b_mreq = reqs(4'b1101); b_sresp = {32'hF000_0000 + 32'(c), 1'b1};
            #1;
            exp_r = '0; exp_r[3*RS +: RS] = {32'hF000_0000 + 32'(c), 1'b1};
            checks++; if (b_grant !== 4'b1000) begin errors++; $display("FAIL fp_grant c%0d got %b exp 1000", c, b_grant); end
            checks++; if (b_mresp !== exp_r) begin errors++; $display("FAIL fp_resp c%0d got %h exp %h", c, b_mresp, exp_r); end
        end
        @(negedge clk);
        b_mreq = reqs(4'b0101); b_sresp = {32'h0, 1'b1};
        #1;
        checks++; if (b_grant !== 4'b0100 || b_sreq[67:36] !== addr_of(2)) begin errors++; $display("FAIL fp_low got %b addr %h exp 0100", b_grant, b_sreq[67:36]); end
        @(negedge clk);
        b_mreq = '0; b_sresp = '0;
    endtask

    task automatic test_single;
        logic [RQ-1:0] ra, rb, rc;
        ra = {1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'hF};
        rb = {1'b1, 32'h0000_0104, 32'h5A5A_5A5A, 4'h3};
        rc = {1'b1, 32'h0000_0108, 32'h0F0F_0F0F, 4'hC};
        @(negedge clk); c_mreq = ra; c_sresp = {32'h1111_1111, 1'b1}; #1;
        checks++; if (c_sreq !== ra || c_grant !== 1'b1) begin errors++; $display("FAIL sg_a got %h g %b exp %h g 1", c_sreq, c_grant, ra); end
        checks++; if (c_mresp !== {32'h1111_1111, 1'b1}) begin errors++; $display("FAIL sg_a_resp got %h exp 111111111", c_mresp); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); c_mreq = rb; c_sresp = {32'h0000_0055, 1'b0}; #1;
            checks++; if (c_sreq !== rb || c_mresp !== {32'h0000_0055, 1'b0}) begin errors++; $display("FAIL sg_wait c%0d got %h resp %h", c, c_sreq, c_mresp); end
        end
        @(negedge clk); c_mreq = rb; c_sresp = {32'h2222_2222, 1'b1}; #1;
        checks++; if (c_mresp !== {32'h2222_2222, 1'b1} || c_grant !== 1'b1) begin errors++; $display("FAIL sg_b_resp got %h g %b exp 222222221 g 1", c_mresp, c_grant); end
        @(negedge clk); c_mreq = rc; c_sresp = '0; #1;
        checks++; if (c_grant !== 1'b0 || c_sreq !== '0) begin errors++; $display("FAIL sg_gap got g %b sreq %h exp 0", c_grant, c_sreq); end
        @(negedge clk); c_mreq = rc; c_sresp = {32'h3333_3333, 1'b1}; #1;
        checks++; if (c_sreq !== rc || c_mresp !== {32'h3333_3333, 1'b1}) begin errors++; $display("FAIL sg_c got %h resp %h exp %h", c_sreq, c_mresp, rc); end
        @(negedge clk); c_mreq = '0; c_sresp = '0;
    endtask

    task automatic test_reset_mid_busy;
        a_cycle(4'b0001, 1'b1, 32'h0);
        checks++; if (a_grant !== 4'b0001) begin errors++; $display("FAIL rmb_pre got %b exp 0001", a_grant); end
        a_cycle(4'b1000, 1'b0, 32'h0);
        checks++; if (a_grant !== 4'b1000) begin errors++; $display("FAIL rmb_req got %b exp 1000", a_grant); end
        a_cycle(4'b1000, 1'b0, 32'h0);
        checks++; if (a_grant !== 4'b1000) begin errors++; $display("FAIL rmb_busy got %b exp 1000", a_grant); end
        a_sresp = {32'h7777_7777, 1'b1};
        #1 rst = 1'b1;
        #1;
        checks++; if (a_sreq !== '0 || a_grant !== 4'b0000) begin errors++; $display("FAIL rmb_rst got sreq %h grant %b exp 0", a_sreq, a_grant); end
        checks++; if (a_mresp !== '0 || a_to !== 1'b0) begin errors++; $display("FAIL rmb_resp got %h exp 0", a_mresp); end
        @(negedge clk);
        rst = 1'b0;
        a_mreq = reqs(4'b0011); a_sresp = {32'h0, 1'b1};
        #1;
        checks++; if (a_grant !== 4'b0001) begin errors++; $display("FAIL rmb_tie got %b exp 0001", a_grant); end
        @(negedge clk);
        a_mreq = '0; a_sresp = '0;
    endtask

    initial begin
        rst = 1'b1;
        a_mreq = '0; a_sresp = '0;
        b_mreq = '0; b_sresp = '0;
        c_mreq = '0; c_sresp = '0;
        test_reset();
        test_rr_zero_wait();
        test_lock();
        test_watchdog();
        test_fixed_prio();
        test_single();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
